// File: rtl/fft_pkg.sv
// Shared definitions for the FFT reorder buffer: default sizes, bank state
// encoding and a width-generic bit-reversal helper.
package fft_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int LOG2_N_DEF = 4;
    localparam int LOG2_N_MAX = 10;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    // Reverses the low 'width' bits of 'a'; bits above 'width' come back as 0.
    function automatic logic [LOG2_N_MAX-1:0] bitrev(input logic [LOG2_N_MAX-1:0] a,
                                                     input int                    width);
        logic [LOG2_N_MAX-1:0] src;
        logic [LOG2_N_MAX-1:0] r;
        src = a;
        r   = '0;
        for (int i = 0; i < LOG2_N_MAX; i++) begin
            if (i < width) begin
                r   = {r[LOG2_N_MAX-2:0], src[0]};
                src = src >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One frame bank of the reorder buffer: N-word storage, its
// EMPTY/FILLING/FULL/DRAINING state and the per-frame ordering mode bit.
module fft_reorder_bank
    import fft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LOG2_N = LOG2_N_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic                wr_last,
    input  logic [LOG2_N-1:0]   wr_addr,
    input  logic [2*DATA_W-1:0] wr_data,
    input  logic                mode_in,
    input  logic                rd_en,
    input  logic                rd_last,
    input  logic [LOG2_N-1:0]   rd_addr,
    output logic [2*DATA_W-1:0] rd_data,
    output bank_state_e         state,
    output logic                mode
);

    localparam int N = 1 << LOG2_N;

    logic [2*DATA_W-1:0] mem [N];
    bank_state_e         state_next;

    // NOTE: storage has no reset; stale words are never visible because the
    // bank only reads out after a complete frame has overwritten every entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BANK_EMPTY;
            mode  <= 1'b0;
        end else begin
            state <= state_next;
            if (wr_en && state == BANK_EMPTY) begin
                mode <= mode_in;
            end
        end
    end

    // NOTE: next state defaults to the current state before the case so no
    // path through the block leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            BANK_EMPTY:    if (wr_en)   state_next = wr_last ? BANK_FULL : BANK_FILLING;
            BANK_FILLING:  if (wr_en && wr_last) state_next = BANK_FULL;
            BANK_FULL:     if (rd_en)   state_next = rd_last ? BANK_EMPTY : BANK_DRAINING;
            BANK_DRAINING: if (rd_en && rd_last) state_next = BANK_EMPTY;
            default:       state_next = BANK_EMPTY;
        endcase
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft_reorder_buf.sv
// Ping-pong frame reorder buffer: fills one bank while draining the other,
// emitting each frame in natural or bit-reversed order. Frame markers
// out_sof/out_eof exist only when FFT_REORDER_MARK_EN is defined.
module fft_reorder_buf
    import fft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LOG2_N = LOG2_N_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_push,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    input  logic              in_bitrev,
    output logic              in_stall,
    output logic              out_push,
    input  logic              out_stall,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag
`ifdef FFT_REORDER_MARK_EN
    ,
    output logic              out_sof,
    output logic              out_eof
`endif
);

    logic                wbank;
    logic                rbank;
    logic [LOG2_N-1:0]   wcnt;
    logic [LOG2_N-1:0]   rcnt;

    bank_state_e         bank_state   [2];
    logic                bank_mode    [2];
    logic [2*DATA_W-1:0] bank_rd_data [2];

    logic                in_xfer;
    logic                out_xfer;
    logic                wr_last;
    logic                rd_last;
    logic                wr_mode;
    logic [LOG2_N-1:0]   wr_addr;

    // Flags depend only on registered bank state, never on out_stall.
    assign in_stall = (bank_state[wbank] == BANK_FULL) || (bank_state[wbank] == BANK_DRAINING);
    assign out_push = (bank_state[rbank] == BANK_FULL) || (bank_state[rbank] == BANK_DRAINING);

    assign in_xfer  = in_push && !in_stall;
    assign out_xfer = out_push && !out_stall;
    assign wr_last  = &wcnt;
    assign rd_last  = &rcnt;

    // The first sample of a frame uses the live mode; the bank latches it then.
    always_comb begin
        wr_mode = (wcnt == '0) ? in_bitrev : bank_mode[wbank];
        wr_addr = wr_mode ? LOG2_N'(bitrev(LOG2_N_MAX'(wcnt), LOG2_N)) : wcnt;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_reorder_bank #(
            .DATA_W (DATA_W),
            .LOG2_N (LOG2_N)
        ) u_bank (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (in_xfer && (wbank == 1'(b))),
            .wr_last (wr_last),
            .wr_addr (wr_addr),
            .wr_data ({in_real, in_imag}),
            .mode_in (in_bitrev),
            .rd_en   (out_xfer && (rbank == 1'(b))),
            .rd_last (rd_last),
            .rd_addr (rcnt),
            .rd_data (bank_rd_data[b]),
            .state   (bank_state[b]),
            .mode    (bank_mode[b])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wbank <= 1'b0;
            rbank <= 1'b0;
            wcnt  <= '0;
            rcnt  <= '0;
        end else begin
            if (in_xfer) begin
                wcnt <= wcnt + 1'b1;
                if (wr_last) wbank <= ~wbank;
            end
            if (out_xfer) begin
                rcnt <= rcnt + 1'b1;
                if (rd_last) rbank <= ~rbank;
            end
        end
    end

    // Data is forced to zero while idle so unwritten storage never leaks out.
    always_comb begin
        out_real = '0;
        out_imag = '0;
        if (out_push) begin
            out_real = bank_rd_data[rbank][2*DATA_W-1:DATA_W];
            out_imag = bank_rd_data[rbank][DATA_W-1:0];
        end
    end

`ifdef FFT_REORDER_MARK_EN
    assign out_sof = out_push && (rcnt == '0);
    assign out_eof = out_push && rd_last;
`endif

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Self-checking bench for fft_reorder_buf: table-driven impulse frames plus
// streaming, back-pressure and mid-frame reset sequences.
module tb_fft_reorder_buf;

    localparam int DATA_W = 16;
    localparam int LOG2_N = 4;
    localparam int N      = 16;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              in_push   = 1'b0;
    logic [DATA_W-1:0] in_real   = '0;
    logic [DATA_W-1:0] in_imag   = '0;
    logic              in_bitrev = 1'b0;
    logic              out_stall = 1'b0;
    logic              in_stall;
    logic              out_push;
    logic [DATA_W-1:0] out_real;
    logic [DATA_W-1:0] out_imag;
`ifdef FFT_REORDER_MARK_EN
    logic              out_sof;
    logic              out_eof;
`endif

    fft_reorder_buf #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_push   (in_push),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .in_bitrev (in_bitrev),
        .in_stall  (in_stall),
        .out_push  (out_push),
        .out_stall (out_stall),
        .out_real  (out_real),
        .out_imag  (out_imag)
`ifdef FFT_REORDER_MARK_EN
        ,
        .out_sof   (out_sof),
        .out_eof   (out_eof)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        br;
        int          in_pos;
        int          exp_pos;
        logic [15:0] re;
        logic [15:0] im;
    } vec_t;

    vec_t        vecs [7];
    int          n_checks     = 0;
    int          n_pass       = 0;
    int          acc          = 0;
    int          stall_cycles = 0;
    int          mon_cnt      = 0;
    logic        prev_hold    = 1'b0;
    logic [31:0] prev_data    = '0;
    logic [31:0] got_q [$];
    logic [31:0] exp_q [$];
    logic [15:0] fr_re [N];
    logic [15:0] fr_im [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int bitrev4(input int v);
        logic [3:0] a;
        a = 4'(v);
        return int'({a[0], a[1], a[2], a[3]});
    endfunction

    // Output monitor: captures transfers, checks hold-while-stalled and markers.
    always @(negedge clk) begin
        if (!reset) begin
            prev_hold = 1'b0;
            mon_cnt   = 0;
        end else begin
            if (prev_hold) begin
                check("hold_out_push", out_push, 1);
                check("hold_out_data", {out_real, out_imag}, prev_data);
            end
`ifdef FFT_REORDER_MARK_EN
            check("out_sof", out_sof, out_push && (mon_cnt % N == 0));
            check("out_eof", out_eof, out_push && (mon_cnt % N == N - 1));
`endif
            if (out_push && !out_stall) begin
                got_q.push_back({out_real, out_imag});
                mon_cnt++;
            end
            prev_hold = out_push && out_stall;
            prev_data = {out_real, out_imag};
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Must be entered just after a rising edge; returns just after the edge
    // that accepted the sample.
    task automatic send(input logic [15:0] re, input logic [15:0] im, input logic br);
        int waited = 0;
        in_push   = 1'b1;
        in_real   = re;
        in_imag   = im;
        in_bitrev = br;
        @(negedge clk);
        while (in_stall && waited < 200) begin
            stall_cycles++;
            waited++;
            @(negedge clk);
        end
        if (waited >= 200) check("send_accept_timeout", in_stall, 0);
        @(posedge clk);
        #1;
        acc++;
        in_push = 1'b0;
    endtask

    task automatic send_frame(input logic mode, input logic toggle);
        for (int i = 0; i < N; i++)
            send(fr_re[i], fr_im[i], (i == 0 || !toggle) ? mode : (mode ^ 1'(i & 1)));
    endtask

    task automatic model_frame(input logic mode);
        for (int p = 0; p < N; p++) begin
            int src = mode ? bitrev4(p) : p;
            exp_q.push_back({fr_re[src], fr_im[src]});
        end
    endtask

    task automatic wait_count(input string name, input int n);
        int b = 0;
        while (got_q.size() < n && b < 500) begin
            @(negedge clk);
            #1;
            b++;
        end
        check(name, got_q.size(), n);
    endtask

    task automatic compare(input string name);
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) check($sformatf("%s[%0d]", name, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0,  0,  0, 16'h7fff, 16'h0000};
        vecs[1] = '{1'b1,  1,  8, 16'h7fff, 16'h0000};
        vecs[2] = '{1'b1,  3, 12, 16'h7fff, 16'h0000};
        vecs[3] = '{1'b0,  9,  9, 16'h8000, 16'h1234};
        vecs[4] = '{1'b1,  6,  6, 16'h0001, 16'hffff};
        vecs[5] = '{1'b1, 15, 15, 16'ha5a5, 16'h5a5a};
        vecs[6] = '{1'b1,  4,  2, 16'h8001, 16'h7ffe};

        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_stall", in_stall, 0);
        check("rst_out_push", out_push, 0);
        check("rst_out_real", out_real, 0);
        check("rst_out_imag", out_imag, 0);
`ifdef FFT_REORDER_MARK_EN
        check("rst_out_sof", out_sof, 0);
        check("rst_out_eof", out_eof, 0);
`endif
        align();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_out_push", out_push, 0);
        check("idle_in_stall", in_stall, 0);

        // Impulse frames with hand-computed output positions.
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < N; i++) begin
                fr_re[i] = (i == vecs[v].in_pos) ? vecs[v].re : 16'h0;
                fr_im[i] = (i == vecs[v].in_pos) ? vecs[v].im : 16'h0;
                exp_q.push_back((i == vecs[v].exp_pos) ? {vecs[v].re, vecs[v].im} : 32'h0);
            end
            align();
            send_frame(vecs[v].br, 1'b0);
            check($sformatf("vec%0d_latency_out_push", v), out_push, 1);
            wait_count($sformatf("vec%0d_count", v), N);
            compare($sformatf("vec%0d_out", v));
        end

        // Four back-to-back ramp frames, alternating mode, in_bitrev wiggled mid-frame.
        stall_cycles = 0;
        align();
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++) begin
                fr_re[i] = 16'(f * N + i);
                fr_im[i] = -16'(f * N + i);
            end
            model_frame(1'(f & 1));
            send_frame(1'(f & 1), 1'b1);
        end
        check("stream_no_stall", stall_cycles, 0);
        wait_count("stream_count", 4 * N);
        compare("stream_out");

        // Back-pressure: consumer stalled for 40 cycles while producer pushes 3 frames.
        align();
        out_stall = 1'b1;
        acc = 0;
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    for (int i = 0; i < N; i++) begin
                        fr_re[i] = 16'h0100 + 16'(f * N + i);
                        fr_im[i] = 16'hf000 - 16'(f * N + i);
                    end
                    model_frame(1'(~f & 1));
                    send_frame(1'(~f & 1), 1'b0);
                end
            end
            begin
                int b = 0;
                repeat (40) @(negedge clk);
                check("bp_accepted", acc, 2 * N);
                check("bp_in_stall", in_stall, 1);
                align();
                out_stall = 1'b0;
                while (got_q.size() < N && b < 200) begin
                    @(negedge clk);
                    #1;
                    b++;
                end
                check("bp_in_stall_last_out", in_stall, 1);
                @(negedge clk);
                #1;
                check("bp_in_stall_released", in_stall, 0);
            end
        join
        wait_count("bp_count", 3 * N);
        compare("bp_out");

        // Reset in the middle of a frame discards the partial frame.
        align();
        for (int i = 0; i < 7; i++) send(16'h0aa0 + 16'(i), 16'h0550 + 16'(i), 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_out_push", out_push, 0);
        check("midrst_in_stall", in_stall, 0);
        align();
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_no_partial", got_q.size(), 0);
        for (int i = 0; i < N; i++) begin
            fr_re[i] = 16'h4000 + 16'(i * 3);
            fr_im[i] = 16'hc000 - 16'(i * 5);
        end
        model_frame(1'b1);
        align();
        send_frame(1'b1, 1'b0);
        wait_count("midrst_count", N);
        repeat (20) @(negedge clk);
        check("midrst_alone", got_q.size(), N);
        compare("midrst_out");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
